// File: rtl/multicycle_ctrl_if.sv
// Control/datapath handshake bundle for the multicycle controller.
//   run, opcode, zero, mem_ready      : datapath/environment -> controller
//   pc_we, ir_we, reg_we, mem_re,
//   mem_we, regdst, alu_src, mem2reg,
//   pc_src[1:0]                       : controller -> datapath
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic       run;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       regdst;
    logic       alu_src;
    logic       mem2reg;
    logic [1:0] pc_src;

    modport master (
        input  run, opcode, zero, mem_ready,
        output pc_we, ir_we, reg_we, mem_re, mem_we, regdst, alu_src, mem2reg, pc_src
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  pc_we, ir_we, reg_we, mem_re, mem_we, regdst, alu_src, mem2reg, pc_src
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : multicycle_ctrl_if.master (fetch enable, opcode, ALU zero,
//                memory ready in; datapath enables and mux selects out)
//   state      : current FSM state (FETCH=0 .. HALT=5)
//   fault      : 0 none, 1 illegal opcode/state, 2 memory timeout (sticky)
//   retired    : wrapping count of completed instructions
// Datapath outputs are combinational from the state, latched instruction
// class, zero and mem_ready; only DECODE looks at the live opcode.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_if.master    bus,
    output logic [2:0]           state,
    output logic [1:0]           fault,
    output logic [RET_W-1:0]     retired
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_ILL  = 2'd1;
    localparam logic [1:0] FAULT_MEM  = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL
    } iclass_t;

    state_t               state_q, state_d;
    iclass_t              class_q, class_d, dec_class;
    logic [1:0]           fault_q, fault_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [RET_W-1:0]     retired_q;
    logic                 ret_inc;

    logic                 pc_we_c, ir_we_c, reg_we_c, mem_re_c, mem_we_c;
    logic                 regdst_c, alu_src_c, mem2reg_c;
    logic [1:0]           pc_src_c;

    // Opcode to instruction class
    always_comb begin
        case (bus.opcode)
            OP_R:    dec_class = C_R;
            OP_ADDI: dec_class = C_ADDI;
            OP_LW:   dec_class = C_LW;
            OP_SW:   dec_class = C_SW;
            OP_BEQ:  dec_class = C_BEQ;
            OP_J:    dec_class = C_J;
            default: dec_class = C_ILL;
        endcase
    end

    // Next state, bookkeeping and datapath controls
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        fault_d   = fault_q;
        wait_d    = wait_q;
        ret_inc   = 1'b0;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        mem_re_c  = 1'b0;
        mem_we_c  = 1'b0;
        regdst_c  = 1'b0;
        alu_src_c = 1'b0;
        mem2reg_c = 1'b0;
        pc_src_c  = 2'd0;

        case (state_q)
            S_FETCH: begin
                if (bus.run) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                class_d = dec_class;
                case (dec_class)
                    C_J: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = 2'd2;
                        ret_inc  = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_ILL: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILL;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_src_c = (class_q == C_ADDI) || (class_q == C_LW) || (class_q == C_SW);
                case (class_q)
                    C_R, C_ADDI: state_d = S_WB;
                    C_LW, C_SW: begin
                        wait_d  = '0;
                        state_d = S_MEM;
                    end
                    C_BEQ: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = {1'b0, bus.zero};
                        ret_inc  = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILL;
                    end
                endcase
            end
            S_MEM: begin
                mem_re_c = (class_q == C_LW);
                mem_we_c = (class_q == C_SW);
                if (bus.mem_ready) begin
                    if (class_q == C_SW) begin
                        pc_we_c = 1'b1;
                        ret_inc = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    // Last permitted wait cycle without ready: give up.
                    state_d = S_HALT;
                    fault_d = FAULT_MEM;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_we_c  = 1'b1;
                pc_we_c   = 1'b1;
                regdst_c  = (class_q == C_R);
                mem2reg_c = (class_q != C_LW);
                ret_inc   = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                state_d = S_HALT;
                fault_d = FAULT_ILL;
            end
        endcase

        // Enables must drop the moment reset asserts, not at the next edge.
        if (!rst_n) begin
            pc_we_c  = 1'b0;
            ir_we_c  = 1'b0;
            reg_we_c = 1'b0;
            mem_re_c = 1'b0;
            mem_we_c = 1'b0;
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            class_q   <= C_R;
            fault_q   <= FAULT_NONE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
            if (ret_inc) begin
                retired_q <= retired_q + RET_W'(1);
            end
        end
    end

    assign bus.pc_we   = pc_we_c;
    assign bus.ir_we   = ir_we_c;
    assign bus.reg_we  = reg_we_c;
    assign bus.mem_re  = mem_re_c;
    assign bus.mem_we  = mem_we_c;
    assign bus.regdst  = regdst_c;
    assign bus.alu_src = alu_src_c;
    assign bus.mem2reg = mem2reg_c;
    assign bus.pc_src  = pc_src_c;

    assign state   = state_q;
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The stimulus side walks each
// instruction through its cycle script and queues the expected outputs for
// every cycle; the monitor pops one entry per cycle at the falling edge.
module tb_multicycle_ctrl;

    localparam int unsigned MEM_TIMEOUT = 16;
    // Narrow counter so the wrap-around is reachable in a short run.
    localparam int unsigned RET_W = 10;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic [2:0]       st;
        logic             pc_we;
        logic             ir_we;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
        logic [1:0]       pc_src;
        logic             alu_src;
        logic             regdst;
        logic             mem2reg;
        logic [1:0]       fault;
        logic [RET_W-1:0] ret;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       state;
    logic [1:0]       fault;
    logic [RET_W-1:0] retired;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .RET_W(RET_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state   (state),
        .fault   (fault),
        .retired (retired)
    );

    always #5 clk = ~clk;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [RET_W-1:0] exp_ret  = '0;
    logic [1:0]       cur_fault = 2'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Monitor: one expected entry per cycle; selects only checked where used.
    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        if (exp_q.size() != 0) begin
            e           = exp_q.pop_front();
            act         = '0;
            act.st      = state;
            act.pc_we   = bus.pc_we;
            act.ir_we   = bus.ir_we;
            act.reg_we  = bus.reg_we;
            act.mem_re  = bus.mem_re;
            act.mem_we  = bus.mem_we;
            act.pc_src  = bus.pc_src;
            act.alu_src = (e.st == 3'd2) ? bus.alu_src : 1'b0;
            act.regdst  = (e.st == 3'd4) ? bus.regdst  : 1'b0;
            act.mem2reg = (e.st == 3'd4) ? bus.mem2reg : 1'b0;
            act.fault   = fault;
            act.ret     = retired;
            check($sformatf("cycle_st%0d", e.st), 64'(act), 64'(e));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e = '0;
        e.st    = st;
        e.fault = cur_fault;
        e.ret   = exp_ret;
        return e;
    endfunction

    // Inputs that must not matter in the coming cycle get random values.
    task automatic scramble();
        bus.run       = 1'($urandom);
        bus.opcode    = 6'($urandom);
        bus.zero      = 1'($urandom);
        bus.mem_ready = 1'($urandom);
    endtask

    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; reset must act without a clock edge.
    task automatic reset_pulse();
        exp_t e;
        bus.run = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("rst_state",   64'(state), 64'(0));
        check("rst_fault",   64'(fault), 64'(0));
        check("rst_retired", 64'(retired), 64'(0));
        check("rst_enables", 64'({bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_re, bus.mem_we}), 64'(0));
        #1;
        rst_n   = 1'b1;
        bus.run = 1'b0;
        exp_ret   = '0;
        cur_fault = 2'd0;
        e = base(3'd0);
        cyc(e);
    endtask

    task automatic halt_then_reset();
        repeat (3) begin
            scramble();
            bus.run = 1'b1;
            cyc(base(3'd5));
        end
        reset_pulse();
    endtask

    task automatic fetch(input int idle);
        exp_t e;
        for (int i = 0; i < idle; i++) begin
            scramble();
            bus.run = 1'b0;
            cyc(base(3'd0));
        end
        scramble();
        bus.run = 1'b1;
        e = base(3'd0);
        e.ir_we = 1'b1;
        cyc(e);
    endtask

    // One instruction; k = MEM cycles with mem_ready low before it rises.
    task automatic do_instr(input logic [5:0] op, input int k, input logic z, input int idle);
        exp_t e;
        bit   is_lw = (op == OP_LW);
        bit   is_sw = (op == OP_SW);
        fetch(idle);
        scramble();
        bus.opcode = op;
        e = base(3'd1);
        if (op == OP_J) begin
            e.pc_we  = 1'b1;
            e.pc_src = 2'd2;
            cyc(e);
            exp_ret = exp_ret + RET_W'(1);
            return;
        end
        cyc(e);
        if (!is_legal(op)) begin
            cur_fault = 2'd1;
            halt_then_reset();
            return;
        end
        scramble();
        bus.zero = z;
        e = base(3'd2);
        e.alu_src = (op == OP_ADDI) || is_lw || is_sw;
        if (op == OP_BEQ) begin
            e.pc_we  = 1'b1;
            e.pc_src = {1'b0, z};
            cyc(e);
            exp_ret = exp_ret + RET_W'(1);
            return;
        end
        cyc(e);
        if (is_lw || is_sw) begin
            for (int i = 0; i < k && i < int'(MEM_TIMEOUT); i++) begin
                scramble();
                bus.mem_ready = 1'b0;
                e = base(3'd3);
                e.mem_re = is_lw;
                e.mem_we = is_sw;
                cyc(e);
            end
            if (k >= int'(MEM_TIMEOUT)) begin
                cur_fault = 2'd2;
                halt_then_reset();
                return;
            end
            scramble();
            bus.mem_ready = 1'b1;
            e = base(3'd3);
            e.mem_re = is_lw;
            e.mem_we = is_sw;
            if (is_sw) begin
                e.pc_we = 1'b1;
                cyc(e);
                exp_ret = exp_ret + RET_W'(1);
                return;
            end
            cyc(e);
        end
        scramble();
        e = base(3'd4);
        e.reg_we  = 1'b1;
        e.pc_we   = 1'b1;
        e.regdst  = (op == OP_R);
        e.mem2reg = !is_lw;
        cyc(e);
        exp_ret = exp_ret + RET_W'(1);
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        exp_t       e;
        ops[0] = OP_R;  ops[1] = OP_ADDI; ops[2] = OP_LW;
        ops[3] = OP_SW; ops[4] = OP_BEQ;  ops[5] = OP_J;

        // Power-on reset with run high: enables must stay low.
        rst_n = 1'b0;
        scramble();
        bus.run = 1'b1;
        #3;
        check("por_state",   64'(state), 64'(0));
        check("por_fault",   64'(fault), 64'(0));
        check("por_retired", 64'(retired), 64'(0));
        check("por_enables", 64'({bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_re, bus.mem_we}), 64'(0));
        #9;
        rst_n   = 1'b1;
        bus.run = 1'b0;
        @(posedge clk);
        #1;

        // Directed sequences
        do_instr(OP_R,    0, 1'b0, 0);
        do_instr(OP_ADDI, 0, 1'b0, 0);
        check("two_retired", 64'(retired), 64'(2));
        do_instr(OP_BEQ,  0, 1'b1, 1);
        do_instr(OP_BEQ,  0, 1'b0, 0);
        do_instr(OP_LW,   3, 1'b0, 2);
        do_instr(OP_SW,   0, 1'b0, 0);
        do_instr(OP_LW,   0, 1'b0, 0);
        do_instr(OP_J,    0, 1'b0, 1);

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            do_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 4), 1'($urandom), $urandom_range(0, 2));
        end

        // Store that never completes, then illegal opcodes
        do_instr(OP_SW, MEM_TIMEOUT, 1'b0, 0);
        do_instr(6'b111111, 0, 1'b0, 0);
        op = 6'($urandom);
        for (int i = 0; i < 64 && is_legal(op); i++) op = 6'($urandom);
        if (is_legal(op)) op = 6'b010101;
        do_instr(op, 0, 1'b0, 1);

        // Reset while a load is waiting in MEM
        do_instr(OP_ADDI, 0, 1'b0, 0);
        fetch(0);
        scramble();
        bus.opcode = OP_LW;
        cyc(base(3'd1));
        scramble();
        e = base(3'd2);
        e.alu_src = 1'b1;
        cyc(e);
        scramble();
        bus.mem_ready = 1'b0;
        #1;
        check("mem_re_before_rst", 64'(bus.mem_re), 64'(1));
        reset_pulse();

        // Retired counter wrap via jumps
        for (int i = 0; i < (1 << RET_W) - 1; i++) do_instr(OP_J, 0, 1'b0, $urandom_range(0, 1));
        check("pre_wrap", 64'(retired), 64'((1 << RET_W) - 1));
        do_instr(OP_J, 0, 1'b0, 0);
        check("wrap", 64'(retired), 64'(0));

        scramble();
        bus.run = 1'b0;
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
